// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: frame geometry, FSM state encoding and divider sizing.
package uart_transmitter_pkg;

  localparam int OVERSAMPLE      = 16;
  localparam int DATA_BITS       = 8;
  localparam int CLK_DIV_DEFAULT = 651;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // A divide-by-1 still needs a one-bit counter to stay legal.
  function automatic int div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Clearable clock divider: one-cycle tick every CLK_DIV clocks, held at zero while clr.
module uart_baud_tick
  import uart_transmitter_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int            W    = div_width(CLK_DIV);
  localparam logic [W-1:0]  LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_reg;
  logic         wrap;

  assign wrap = (div_reg == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_reg <= '0;
    end else if (clr || wrap) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  assign tick = wrap & ~clr;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1 framing, 16x oversample timebase, registered outputs.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       TXEn,
  input  logic       TXStart,
  input  logic [7:0] TXData,
  output logic       UARTTx,
  output logic       TXBusy,
  output logic       TXStatus
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  uart_state_t           state_reg, state_next;
  logic [DATA_BITS-1:0]  shift_reg, shift_next;
  logic [TICK_W-1:0]     tick_cnt_reg, tick_cnt_next;
  logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic                  tx_reg, tx_next;
  logic                  busy_reg, busy_next;
  logic                  status_reg, status_next;
  logic                  tick;
  logic                  bit_done;
  logic                  accept;

  // Divider only runs while a frame is in flight, so every bit starts phase-aligned.
  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state_reg == ST_IDLE),
    .tick  (tick)
  );

  assign bit_done = tick && (tick_cnt_reg == TICK_W'(OVERSAMPLE - 1));
  assign accept   = TXStart && TXEn && !busy_reg;

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    status_next   = 1'b0;

    if (state_reg == ST_IDLE) begin
      tick_cnt_next = '0;
    end else if (tick) begin
      tick_cnt_next = tick_cnt_reg + 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_START;
          shift_next = TXData;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_next   = ST_DATA;
          bit_cnt_next = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == BIT_W'(DATA_BITS - 1)) begin
            state_next = ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          state_next  = ST_IDLE;
          status_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    case (state_next)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = shift_next[0];
      default:  tx_next = 1'b1;
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      status_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      status_reg   <= status_next;
    end
  end

  assign UARTTx   = tx_reg;
  assign TXBusy   = busy_reg;
  assign TXStatus = status_reg;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at CLK_DIV=4 (64 clocks per bit).
module tb_uart_transmitter;

  localparam int CLK_DIV  = 4;
  localparam int BIT_CLKS = 16 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       TXEn;
  logic       TXStart;
  logic [7:0] TXData;
  logic       UARTTx;
  logic       TXBusy;
  logic       TXStatus;

  int n_checks   = 0;
  int n_fail     = 0;
  int status_cnt = 0;

  uart_transmitter #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .TXEn     (TXEn),
    .TXStart  (TXStart),
    .TXData   (TXData),
    .UARTTx   (UARTTx),
    .TXBusy   (TXBusy),
    .TXStatus (TXStatus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (TXStatus === 1'b1) status_cnt <= status_cnt + 1;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with TXStart low; returns at the negedge of the TXStatus cycle.
  task automatic run_frame(input logic [7:0] data, input int inj_bit,
                           input logic [7:0] inj_data, input string name);
    logic [9:0] frame;
    int         match_cnt;
    int         busy_cnt;
    frame   = {1'b1, data, 1'b0};
    TXStart = 1'b1;
    TXData  = data;
    @(negedge clk);
    TXStart  = 1'b0;
    TXData   = ~data;
    busy_cnt = 0;
    for (int b = 0; b < 10; b++) begin
      match_cnt = 0;
      for (int c = 0; c < BIT_CLKS; c++) begin
        if (UARTTx === frame[b]) match_cnt++;
        if (TXBusy === 1'b1) busy_cnt++;
        TXStart = (b == inj_bit) && (c == 10);
        if ((b == inj_bit) && (c == 10)) TXData = inj_data;
        @(negedge clk);
      end
      check_value($sformatf("%s bit%0d", name, b), match_cnt, BIT_CLKS);
    end
    check_value({name, " busy_clks"}, busy_cnt, 10 * BIT_CLKS);
    check_value({name, " busy_end"}, TXBusy, 1'b0);
    check_value({name, " status_end"}, TXStatus, 1'b1);
    check_value({name, " line_end"}, UARTTx, 1'b1);
  endtask

  initial begin
    int idle_cnt;
    int busy_cnt;
    int saved;
    logic [7:0] rnd;

    reset   = 1'b0;
    TXEn    = 1'b0;
    TXStart = 1'b0;
    TXData  = 8'h00;
    repeat (3) @(negedge clk);
    check_value("rst tx", UARTTx, 1'b1);
    check_value("rst busy", TXBusy, 1'b0);
    check_value("rst status", TXStatus, 1'b0);
    reset = 1'b1;

    // Test 1: idle line after reset
    idle_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (UARTTx === 1'b1) idle_cnt++;
      if (TXBusy === 1'b0 && TXStatus === 1'b0) busy_cnt++;
    end
    check_value("idle tx", idle_cnt, 1000);
    check_value("idle busy", busy_cnt, 1000);
    $display("test1 idle after reset done");

    // Test 2: single 8'hA5 frame
    TXEn = 1'b1;
    run_frame(8'hA5, -1, 8'h00, "a5");
    @(negedge clk);
    check_value("a5 status_cnt", status_cnt, 1);
    check_value("a5 status_width", TXStatus, 1'b0);
    $display("test2 frame 0xa5 done");

    // Test 3: TXStart during frame bit 4 is ignored
    run_frame(8'hA5, 4, 8'h3C, "a5_inj");
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_value("inj status_cnt", status_cnt, 2);
    check_value("inj no_frame", TXBusy, 1'b0);
    $display("test3 ignored start during frame done");

    // Test 4: TXEn low blocks acceptance
    TXEn    = 1'b0;
    TXStart = 1'b1;
    TXData  = 8'h00;
    @(negedge clk);
    TXStart  = 1'b0;
    idle_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (UARTTx === 1'b1) idle_cnt++;
      if (TXBusy === 1'b0) busy_cnt++;
      @(negedge clk);
    end
    check_value("en0 tx", idle_cnt, 100);
    check_value("en0 busy", busy_cnt, 100);
    $display("test4 txen low done");

    // Test 5: reset during data bit 3 abandons the frame
    TXEn    = 1'b1;
    TXStart = 1'b1;
    TXData  = 8'h00;
    @(negedge clk);
    TXStart = 1'b0;
    repeat (4 * BIT_CLKS + 20 - 1) @(negedge clk);
    check_value("mid busy", TXBusy, 1'b1);
    check_value("mid tx", UARTTx, 1'b0);
    saved = status_cnt;
    #2 reset = 1'b0;
    #1;
    check_value("async tx", UARTTx, 1'b1);
    check_value("async busy", TXBusy, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_value("abandon status_cnt", status_cnt, saved);
    check_value("abandon tx", UARTTx, 1'b1);
    run_frame(8'h5A, -1, 8'h00, "5a");
    @(negedge clk);
    check_value("5a status_cnt", status_cnt, saved + 1);
    $display("test5 reset mid-frame done");

    // Test 6: start accepted in the TXStatus cycle, then random back-to-back bytes
    saved = status_cnt;
    run_frame(8'hFF, -1, 8'h00, "ff");
    run_frame(8'h00, -1, 8'h00, "00");
    for (int k = 0; k < 6; k++) begin
      rnd = 8'($urandom_range(0, 255));
      run_frame(rnd, -1, 8'h00, $sformatf("rnd%0d_%02h", k, rnd));
    end
    @(negedge clk);
    check_value("b2b status_cnt", status_cnt, saved + 8);
    check_value("b2b idle", TXBusy, 1'b0);
    $display("test6 back-to-back frames done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
